// File: rtl/alu_scan_ctrl.sv
// Scan sequencer for the ALU chain: takes one pattern, shifts it in, captures, unloads and compares; 2*CHAIN_LEN+3 cycles per pattern.
// start is ignored while busy (ready low). Define ALU_SCAN_CTRL_MISR_EN to build the response MISR on signature, else signature is 0.
module alu_scan_ctrl #(
  parameter int                   CHAIN_LEN = 4,
  parameter logic [CHAIN_LEN-1:0] POLY      = 4'b0011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 ready,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response,
  output logic [7:0]           fail_count,
  output logic [CHAIN_LEN-1:0] signature
);

  localparam int               CNT_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_IN  = 3'd1;
  localparam logic [2:0] CAPTURE   = 3'd2;
  localparam logic [2:0] SHIFT_OUT = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     bit_idx;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-2:0] cap_q, cap_d;
  logic [CHAIN_LEN-1:0] unload;
  logic                 ready_q, ready_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic [7:0]           fail_q, fail_d;

  // Outputs are registered, so each one is computed for the state being entered.
  assign bit_idx = LAST_BIT - cnt_q - CNT_W'(1);
  assign unload  = {cap_q, scan_out};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    cap_d     = cap_q;
    ready_d   = 1'b0;
    scan_en_d = 1'b0;
    scan_in_d = 1'b0;
    done_d    = 1'b0;
    pass_d    = pass_q;
    resp_d    = resp_q;
    fail_d    = fail_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          pat_d     = pattern;
          exp_d     = expected;
          cnt_d     = '0;
          state_d   = SHIFT_IN;
          ready_d   = 1'b0;
          scan_en_d = 1'b1;
          scan_in_d = pattern[CHAIN_LEN-1];
        end
      end
      SHIFT_IN: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          scan_en_d = 1'b1;
          scan_in_d = pat_q[bit_idx];
        end
      end
      CAPTURE: begin
        cnt_d     = '0;
        state_d   = SHIFT_OUT;
        scan_en_d = 1'b1;
      end
      SHIFT_OUT: begin
        cap_d = unload[CHAIN_LEN-2:0];
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          done_d  = 1'b1;
          resp_d  = unload;
          pass_d  = (unload == exp_q);
          if (unload != exp_q && fail_q != 8'hFF)
            fail_d = fail_q + 8'd1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          scan_en_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      cap_q     <= '0;
      ready_q   <= 1'b1;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      resp_q    <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      cap_q     <= cap_d;
      ready_q   <= ready_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      resp_q    <= resp_d;
      fail_q    <= fail_d;
    end
  end

`ifdef ALU_SCAN_CTRL_MISR_EN
  logic [CHAIN_LEN-1:0] sig_q, sig_d;

  // Folds in the response registered on the way into DONE.
  always_comb begin
    sig_d = sig_q;
    if (state_q == DONE)
      sig_d = ({sig_q[CHAIN_LEN-2:0], 1'b0} ^ (sig_q[CHAIN_LEN-1] ? POLY : '0)) ^ resp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  // Constant zero; POLY is referenced only to keep it used in this build.
  assign signature = POLY & {CHAIN_LEN{1'b0}};
`endif

  assign ready      = ready_q;
  assign scan_en    = scan_en_q;
  assign scan_in    = scan_in_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign response   = resp_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_alu_scan_ctrl.sv
// Directed bench for alu_scan_ctrl against a 4-bit shift chain that holds its contents on capture.
module tb_alu_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] expected;
  logic       ready, scan_en, scan_in, scan_out, done, pass;
  logic [3:0] response, signature;
  logic [7:0] fail_count;
  logic [3:0] chain = 4'h0;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef ALU_SCAN_CTRL_MISR_EN
  localparam logic [3:0] SIG1 = 4'b1011;
  localparam logic [3:0] SIG2 = 4'b0000;
`else
  localparam logic [3:0] SIG1 = 4'b0000;
  localparam logic [3:0] SIG2 = 4'b0000;
`endif

  always #5 clk = ~clk;

  alu_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .expected(expected),
    .ready(ready), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .done(done), .pass(pass), .response(response), .fail_count(fail_count),
    .signature(signature)
  );

  assign scan_out = chain[3];
  always @(posedge clk) if (scan_en) chain <= {chain[2:0], scan_in};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one pattern from IDLE; returns at the observation point of cycle 13.
  task automatic run(input logic [3:0] pat, input logic [3:0] exp,
                     output int done_cyc, output int n_done,
                     output logic [3:0] si_bits, output logic [11:0] en_tr,
                     output logic [3:0] resp_at, output logic pass_at);
    done_cyc = -1;
    n_done   = 0;
    si_bits  = '0;
    en_tr    = '0;
    resp_at  = 'x;
    pass_at  = 1'bx;
    start    = 1'b1;
    pattern  = pat;
    expected = exp;
    step();
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      en_tr = {scan_en, en_tr[11:1]};
      if (n <= 4) si_bits = {si_bits[2:0], scan_in};
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = n;
          resp_at  = response;
          pass_at  = pass;
        end
      end
      step();
    end
  endtask

  initial begin
    int         dcyc, ndone, total_dones, got;
    logic [3:0] si, resp;
    logic [11:0] en;
    logic       ps;

    rst = 1'b1; start = 1'b0; pattern = '0; expected = '0;
    step();
    step();
    chk("rst_ready", ready, 1);
    chk("rst_scan_en", scan_en, 0);
    chk("rst_scan_in", scan_in, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_response", response, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_signature", signature, 0);
    rst = 1'b0;
    step();

    run(4'b1011, 4'b1011, dcyc, ndone, si, en, resp, ps);
    chk("p1_scan_in_seq", si, 4'b1011);
    chk("p1_scan_en_trace", en, 12'h1EF);
    chk("p1_done_cycle", dcyc, 10);
    chk("p1_done_count", ndone, 1);
    chk("p1_response", resp, 4'b1011);
    chk("p1_pass", ps, 1);
    chk("p1_pass_held", pass, 1);
    chk("p1_fail_count", fail_count, 0);
    chk("p1_signature", signature, SIG1);

    run(4'b0101, 4'b0101, dcyc, ndone, si, en, resp, ps);
    chk("p2_response", resp, 4'b0101);
    chk("p2_pass", ps, 1);
    chk("p2_signature", signature, SIG2);

    run(4'b1011, 4'b0000, dcyc, ndone, si, en, resp, ps);
    chk("f1_done_cycle", dcyc, 10);
    chk("f1_response", resp, 4'b1011);
    chk("f1_pass", ps, 0);
    chk("f1_fail_count", fail_count, 1);

    total_dones = 0;
    for (int i = 0; i < 299; i++) begin
      run(4'b1011, 4'b0000, dcyc, ndone, si, en, resp, ps);
      total_dones += ndone;
      if (i == 252) chk("sat_fail_254", fail_count, 254);
    end
    chk("sat_done_count", total_dones, 299);
    chk("sat_fail_255", fail_count, 255);

    // start pulses while busy must be ignored; start in cycle 11 must be taken
    pattern = 4'b1011; expected = 4'b1011; start = 1'b1;
    step();
    dcyc = -1; ndone = 0; resp = 'x; ps = 1'bx;
    for (int n = 1; n <= 12; n++) begin
      if (done === 1'b1) begin
        ndone++;
        dcyc = n;
        resp = response;
        ps   = pass;
      end
      if (n == 12) begin
        chk("restart_ready_low", ready, 0);
        chk("restart_scan_en", scan_en, 1);
        chk("restart_first_bit", scan_in, 1);
      end
      start    = (n == 3 || n == 10 || n == 11);
      pattern  = (n == 11) ? 4'b1000 : 4'b0110;
      expected = (n == 11) ? 4'b1000 : 4'b0110;
      step();
    end
    start = 1'b0;
    chk("busy_done_count", ndone, 1);
    chk("busy_done_cycle", dcyc, 10);
    chk("busy_response", resp, 4'b1011);
    chk("busy_pass", ps, 1);
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      if (done === 1'b1) begin
        got = 1;
        chk("restart_response", response, 4'b1000);
        chk("restart_pass", pass, 1);
      end
      step();
    end
    chk("restart_done_seen", got, 1);
    chk("restart_fail_count", fail_count, 255);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_clears_fail", fail_count, 0);
    pattern = 4'b1011; expected = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n < 7; n++) step();
    chk("mid_shift_out_en", scan_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_scan_en", scan_en, 0);
    chk("async_rst_ready", ready, 1);
    chk("async_rst_done", done, 0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      if (done === 1'b1) ndone++;
      step();
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_fail_count", fail_count, 0);
    chk("abort_ready", ready, 1);
    chk("abort_signature", signature, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
